// File: rtl/cp0_unit_if.sv
// cp0_unit_if -- controller <-> CP0 signal bundle.
// Purpose: groups the mtc0/mfc0 access signals, the interrupt entry/return
// strobes and the CP0 results into one bundle.
// Signals:
//   we       register write strobe (mtc0)
//   sel      CP0 register number (rd field)
//   din      write data (GPR[rt])
//   pc       word address [31:2] to resume at after the interrupt
//   hw_int   level-sensitive external interrupt lines
//   exl_set  interrupt entry strobe
//   exl_clr  interrupt return strobe (eret)
//   dout     read data (mfc0)
//   epc_out  current EPC[31:2] for the eret next-PC path
//   int_req  interrupt request to the controller
// Modports: master = controller/datapath side, slave = CP0 side.
interface cp0_unit_if;
  logic        we;
  logic [4:0]  sel;
  logic [31:0] din;
  logic [29:0] pc;
  logic [5:0]  hw_int;
  logic        exl_set;
  logic        exl_clr;
  logic [31:0] dout;
  logic [29:0] epc_out;
  logic        int_req;

  modport master (
    output we, sel, din, pc, hw_int, exl_set, exl_clr,
    input  dout, epc_out, int_req
  );

  modport slave (
    input  we, sel, din, pc, hw_int, exl_set, exl_clr,
    output dout, epc_out, int_req
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit -- minimal MIPS coprocessor 0 for interrupt handling.
// Purpose: holds SR (IM/EXL/IE), Cause.IP, EPC and a read-only PrID, raises
// int_req for enabled pending interrupts and records the resume address on
// interrupt entry.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset, clears SR, Cause.IP and EPC
//   bus    cp0_unit_if.slave (we, sel, din, pc, hw_int, exl_set, exl_clr in;
//          dout, epc_out, int_req out)
// Parameter:
//   PRID   value returned when reading register 15
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h4D49_5053
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  logic [5:0]  im_q,  im_d;
  logic        exl_q, exl_d;
  logic        ie_q,  ie_d;
  logic [5:0]  ip_q,  ip_d;
  logic [29:0] epc_q, epc_d;

  logic        sr_wr_s;
  logic        epc_wr_s;
  logic [31:0] sr_val_s;
  logic [31:0] cause_val_s;
  logic [31:0] dout_s;

  // Software write decode; an interrupt entry in the same cycle wins.
  always_comb begin
    sr_wr_s  = 1'b0;
    epc_wr_s = 1'b0;
    if (bus.we && !bus.exl_set) begin
      case (bus.sel)
        SEL_SR:  sr_wr_s  = 1'b1;
        SEL_EPC: epc_wr_s = 1'b1;
        default: begin
          sr_wr_s  = 1'b0;
          epc_wr_s = 1'b0;
        end
      endcase
    end else begin
      sr_wr_s  = 1'b0;
      epc_wr_s = 1'b0;
    end
  end

  // Next-state logic for SR, Cause.IP and EPC.
  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;
    // IP simply samples the lines every cycle: no latching of pending requests.
    ip_d  = bus.hw_int;

    if (sr_wr_s) begin
      im_d = bus.din[15:10];
      ie_d = bus.din[0];
    end else begin
      im_d = im_q;
      ie_d = ie_q;
    end

    // EXL priority: entry > return > software write.
    if (bus.exl_set) begin
      exl_d = 1'b1;
    end else if (bus.exl_clr) begin
      exl_d = 1'b0;
    end else if (sr_wr_s) begin
      exl_d = bus.din[1];
    end else begin
      exl_d = exl_q;
    end

    if (bus.exl_set) begin
      epc_d = bus.pc;
    end else if (epc_wr_s) begin
      epc_d = bus.din[31:2];
    end else begin
      epc_d = epc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= 6'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      ip_q  <= 6'd0;
      epc_q <= 30'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end

  assign sr_val_s    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
  assign cause_val_s = {16'h0000, ip_q, 10'h000};

  // mfc0 read mux; unimplemented registers read as zero.
  always_comb begin
    dout_s = 32'h0000_0000;
    case (bus.sel)
      SEL_SR:    dout_s = sr_val_s;
      SEL_CAUSE: dout_s = cause_val_s;
      SEL_EPC:   dout_s = {epc_q, 2'b00};
      SEL_PRID:  dout_s = PRID;
      default:   dout_s = 32'h0000_0000;
    endcase
  end

  assign bus.dout    = dout_s;
  assign bus.epc_out = epc_q;
  assign bus.int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cp0_unit_if bus ();

  cp0_unit #(.PRID(32'h4D49_5053)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    bus.we      = 1'b0;
    bus.exl_set = 1'b0;
    bus.exl_clr = 1'b0;
    bus.din     = 32'h0;
  endtask

  task automatic test_reset();
    logic [4:0]  sels [5];
    logic [31:0] exps [5];
    sels = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    exps = '{32'h0, 32'h0, 32'h0, 32'h4D49_5053, 32'h0};
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sel = sels[i];
      #1;
      vectors++;
      if (bus.dout !== exps[i]) begin
        miscompares++;
        $display("FAIL reset_read sel=%0d: got %h expected %h", sels[i], bus.dout, exps[i]);
      end
    end
    vectors++;
    if (bus.int_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_int_req: got %b expected 0", bus.int_req);
    end
  endtask

  task automatic test_irq();
    bus.we = 1'b1; bus.sel = 5'd12; bus.din = 32'h0000_0401;
    step();
    idle_strobes();
    vectors++;
    if (bus.dout !== 32'h0000_0401) begin
      miscompares++;
      $display("FAIL sr_write: got %h expected 00000401", bus.dout);
    end
    bus.hw_int = 6'b000001;
    bus.sel = 5'd13;
    #1;
    vectors++;
    if (bus.int_req !== 1'b0 || bus.dout !== 32'h0) begin
      miscompares++;
      $display("FAIL irq_before_edge: got int_req=%b cause=%h expected 0/00000000", bus.int_req, bus.dout);
    end
    step();
    vectors++;
    if (bus.dout !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL cause_ip: got %h expected 00000400", bus.dout);
    end
    vectors++;
    if (bus.int_req !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_raise: got %b expected 1", bus.int_req);
    end
  endtask

  task automatic test_exl_entry();
    bus.exl_set = 1'b1; bus.we = 1'b1; bus.sel = 5'd12; bus.din = 32'h0;
    bus.pc = 30'h0000_0C05;
    step();
    idle_strobes();
    bus.sel = 5'd14;
    #1;
    vectors++;
    if (bus.dout !== 32'h0000_3014) begin
      miscompares++;
      $display("FAIL entry_epc: got %h expected 00003014", bus.dout);
    end
    bus.sel = 5'd12;
    #1;
    vectors++;
    if (bus.dout !== 32'h0000_0403) begin
      miscompares++;
      $display("FAIL entry_sr: got %h expected 00000403", bus.dout);
    end
    vectors++;
    if (bus.int_req !== 1'b0 || bus.epc_out !== 30'h0000_0C05) begin
      miscompares++;
      $display("FAIL entry_outs: got int_req=%b epc_out=%h expected 0/0000c05", bus.int_req, bus.epc_out);
    end
  endtask

  task automatic test_exl_return();
    bus.exl_clr = 1'b1;
    step();
    idle_strobes();
    bus.sel = 5'd12;
    #1;
    vectors++;
    if (bus.dout !== 32'h0000_0401) begin
      miscompares++;
      $display("FAIL return_sr: got %h expected 00000401", bus.dout);
    end
    vectors++;
    if (bus.int_req !== 1'b1 || bus.epc_out !== 30'h0000_0C05) begin
      miscompares++;
      $display("FAIL return_outs: got int_req=%b epc_out=%h expected 1/0000c05", bus.int_req, bus.epc_out);
    end
  endtask

  task automatic test_irq_drop();
    bus.hw_int = 6'b000000;
    #1;
    vectors++;
    if (bus.int_req !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_hold: got %b expected 1", bus.int_req);
    end
    step();
    vectors++;
    if (bus.int_req !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_fall: got %b expected 0", bus.int_req);
    end
  endtask

  task automatic test_epc_write();
    bus.we = 1'b1; bus.sel = 5'd14; bus.din = 32'hABCD_1237;
    step();
    idle_strobes();
    vectors++;
    if (bus.dout !== 32'hABCD_1234 || bus.epc_out !== 30'h2AF3_448D) begin
      miscompares++;
      $display("FAIL epc_write: got dout=%h epc_out=%h expected abcd1234/2af3448d", bus.dout, bus.epc_out);
    end
    // Writes to Cause and PrID must be ignored.
    bus.we = 1'b1; bus.sel = 5'd13; bus.din = 32'hFFFF_FFFF;
    step();
    bus.sel = 5'd15;
    step();
    idle_strobes();
    bus.sel = 5'd13;
    #1;
    vectors++;
    if (bus.dout !== 32'h0) begin
      miscompares++;
      $display("FAIL cause_ro: got %h expected 00000000", bus.dout);
    end
    bus.sel = 5'd15;
    #1;
    vectors++;
    if (bus.dout !== 32'h4D49_5053) begin
      miscompares++;
      $display("FAIL prid_ro: got %h expected 4d495053", bus.dout);
    end
  endtask

  task automatic test_priority();
    // Set and clear together: entry wins.
    bus.exl_set = 1'b1; bus.exl_clr = 1'b1; bus.pc = 30'h0000_1234;
    step();
    idle_strobes();
    bus.sel = 5'd12;
    #1;
    vectors++;
    if (bus.dout !== 32'h0000_0403) begin
      miscompares++;
      $display("FAIL set_clr_both: got %h expected 00000403", bus.dout);
    end
    // mtc0 SR with EXL=1 and eret together: eret clears EXL, IM/IE still written.
    bus.we = 1'b1; bus.sel = 5'd12; bus.din = 32'h0000_FC03; bus.exl_clr = 1'b1;
    step();
    idle_strobes();
    vectors++;
    if (bus.dout !== 32'h0000_FC01) begin
      miscompares++;
      $display("FAIL clr_vs_mtc0: got %h expected 0000fc01", bus.dout);
    end
  endtask

  task automatic test_reset_mid();
    bus.exl_set = 1'b1; bus.pc = 30'h0000_0777;
    bus.hw_int = 6'h3F;
    step();
    idle_strobes();
    step();
    vectors++;
    if (bus.int_req !== 1'b0) begin
      miscompares++;
      $display("FAIL exl_masks: got %b expected 0", bus.int_req);
    end
    // Reset overrides a concurrent entry strobe.
    reset = 1'b1; bus.exl_set = 1'b1; bus.pc = 30'h0000_0555;
    step();
    reset = 1'b0;
    idle_strobes();
    for (int s = 12; s <= 14; s++) begin
      bus.sel = 5'(s);
      #1;
      vectors++;
      if (bus.dout !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_mid sel=%0d: got %h expected 00000000", s, bus.dout);
      end
    end
    vectors++;
    if (bus.int_req !== 1'b0 || bus.epc_out !== 30'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outs: got int_req=%b epc_out=%h expected 0/0", bus.int_req, bus.epc_out);
    end
    step();
    bus.sel = 5'd13;
    #1;
    vectors++;
    if (bus.dout !== 32'h0000_FC00) begin
      miscompares++;
      $display("FAIL post_reset_ip: got %h expected 0000fc00", bus.dout);
    end
    vectors++;
    if (bus.int_req !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_irq: got %b expected 0", bus.int_req);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.we      = 1'b0;
    bus.sel     = 5'd0;
    bus.din     = 32'h0;
    bus.pc      = 30'h0;
    bus.hw_int  = 6'h00;
    bus.exl_set = 1'b0;
    bus.exl_clr = 1'b0;
    test_reset();
    test_irq();
    test_exl_entry();
    test_exl_return();
    test_irq_drop();
    test_epc_write();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
